ls_mem_responder: RTL and testbench

Memory-side responder for the Execute stage load/store port. It buffers LS requests (25-bit address, 8-bit data, read/write, Rd tag) in a small FIFO and runs a req/ack transaction on the external byte-wide memory bus. Load data returns to writeback with its Rd tag. It sits between Execute's LS outputs and the external memory/flash controller, and adds wait-state tolerance and a bus timeout.

---
 rtl/ls_pkg.sv | 21 ++
 rtl/ls_req_fifo.sv | 60 ++++++
 rtl/ls_mem_responder.sv | 136 +++++++++++++
 tb/tb_ls_mem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared types and widths for the load/store memory responder.
package ls_pkg;

  localparam int unsigned LS_ADDR_W = 25;
  localparam int unsigned LS_DATA_W = 8;
  localparam int unsigned TAG_W     = 5;

  typedef struct packed {
    logic [LS_ADDR_W-1:0] addr;
    logic [LS_DATA_W-1:0] data;
    logic                 r_nw;
    logic [TAG_W-1:0]     tag;
  } ls_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } ls_state_t;

endpackage

// File: rtl/ls_req_fifo.sv
// Synchronous FIFO of LS requests with a combinational head-of-queue view.
module ls_req_fifo
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  ls_req_t din,
  output ls_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ls_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow requests are dropped so the pointers can never skew.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ls_mem_responder.sv
// Queues Execute-stage LS requests and runs them one at a time on the byte-wide
// memory bus with a req/ack handshake and timeout; loads return to writeback.
module ls_mem_responder
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ls_valid,
  output logic                   ls_ready,
  input  logic [LS_ADDR_W-1:0]   LS_addr,
  input  logic [LS_DATA_W-1:0]   LS_data,
  input  logic                   LS_R_nW,
  input  logic [TAG_W-1:0]       LS_Rd_tag,
  output logic                   mem_req,
  output logic [LS_ADDR_W-1:0]   mem_addr,
  output logic [LS_DATA_W-1:0]   mem_wdata,
  output logic                   mem_we,
  input  logic                   mem_ack,
  input  logic [LS_DATA_W-1:0]   mem_rdata,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [2*LS_DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]       wb_tag,
  output logic                   bus_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

  ls_state_t        state;
  ls_state_t        state_nxt;
  ls_req_t          push_req;
  ls_req_t          head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             timeout;
  logic             rd_done;
  logic             live;
  logic             timer_last;
  logic [TMR_W-1:0] timer;
  logic [TAG_W-1:0] cur_tag;

  assign push_req = '{addr: LS_addr, data: LS_data, r_nw: LS_R_nW, tag: LS_Rd_tag};

  // live holds ls_ready low through reset and for the first cycle after it.
  assign ls_ready   = live && !full;
  assign push       = ls_valid && ls_ready;
  assign mem_req    = (state == REQ);
  assign wb_valid   = (state == RESP);
  assign timer_last = (timer == TMR_W'(TIMEOUT_CYC - 1));

  ls_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_req),
    .head (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    timeout   = 1'b0;
    rd_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // An ack arriving on the last timer cycle completes normally.
        if (mem_ack || timer_last) begin
          timeout   = !mem_ack;
          rd_done   = !mem_we;
          state_nxt = mem_we ? IDLE : RESP;
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live      <= 1'b0;
      bus_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cur_tag   <= '0;
      timer     <= '0;
      wb_data   <= '0;
      wb_tag    <= '0;
    end else begin
      live    <= 1'b1;
      bus_err <= timeout;
      if (pop) begin
        mem_addr  <= head.addr;
        mem_wdata <= head.data;
        mem_we    <= !head.r_nw;
        cur_tag   <= head.tag;
        timer     <= '0;
      end else if (state == REQ) begin
        timer <= timer + TMR_W'(1);
      end
      if (rd_done) begin
        wb_data <= mem_ack ? {{LS_DATA_W{1'b0}}, mem_rdata} : '0;
        wb_tag  <= cur_tag;
      end
    end
  end

endmodule

// File: tb/tb_ls_mem_responder.sv
// Self-checking bench for ls_mem_responder: directed vector table, corner
// sequences, and randomized traffic against a transaction-level model.
module tb_ls_mem_responder;

  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int NEVER = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic        ls_ready;
  logic [24:0] LS_addr;
  logic [7:0]  LS_data;
  logic        LS_R_nW;
  logic [4:0]  LS_Rd_tag;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [4:0]  wb_tag;
  logic        bus_err;

  ls_mem_responder #(
    .DEPTH      (DEPTH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ls_valid (ls_valid),
    .ls_ready (ls_ready),
    .LS_addr  (LS_addr),
    .LS_data  (LS_data),
    .LS_R_nW  (LS_R_nW),
    .LS_Rd_tag(LS_Rd_tag),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_data  (wb_data),
    .wb_tag   (wb_tag),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [4:0]  tag;
  } req_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    logic        rd;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [4:0]  tag;
    int          delay;
    logic [7:0]  rdata;
    int          stall;
    int          exp_req;
    logic        exp_err;
    logic        exp_wb;
    logic [15:0] exp_data;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[8];

  req_t exp_q[$];
  wb_t  wb_exp[$];
  req_t cur;
  logic prev_req;
  logic ack_prev;
  int   req_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ls(input req_t r);
    ls_valid  = 1'b1;
    LS_addr   = r.addr;
    LS_data   = r.data;
    LS_R_nW   = r.rd;
    LS_Rd_tag = r.tag;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    wb_ready = 1'b0;
    drive_ls('{rd: v.rd, addr: v.addr, data: v.data, tag: v.tag});
    chk("vec_push_ready", ls_ready, 1);
    tick();
    ls_valid = 1'b0;
    chk("vec_req_lat1", mem_req, 0);
    tick();
    chk("vec_req_lat2", mem_req, 1);
    chk("vec_we", mem_we, !v.rd);
    if (!v.rd) chk("vec_wdata", mem_wdata, v.data);
    n = 0;
    while (mem_req === 1'b1 && n < 200) begin
      n++;
      chk("vec_addr_hold", mem_addr, v.addr);
      mem_ack   = (v.delay == n - 1);
      mem_rdata = mem_ack ? v.rdata : 8'($urandom);
      tick();
      mem_ack = 1'b0;
    end
    chk("vec_req_cycles", n, v.exp_req);
    chk("vec_req_drop", mem_req, 0);
    chk("vec_bus_err", bus_err, v.exp_err);
    chk("vec_wb_valid", wb_valid, v.exp_wb);
    if (v.exp_wb) begin
      chk("vec_wb_data", wb_data, v.exp_data);
      chk("vec_wb_tag", wb_tag, v.tag);
      for (int s = 0; s < v.stall; s++) begin
        tick();
        chk("stall_valid", wb_valid, 1);
        chk("stall_data", wb_data, v.exp_data);
        chk("stall_tag", wb_tag, v.tag);
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("vec_wb_accept", wb_valid, 0);
    end else begin
      tick();
      chk("vec_no_wb", wb_valid, 0);
    end
    chk("vec_err_pulse_end", bus_err, 0);
    tick();
    chk("vec_idle_after", mem_req, 0);
    chk("vec_no_wb_after", wb_valid, 0);
  endtask

  task automatic rand_step(input bit gen);
    req_t r;
    tick();
    if (mem_req === 1'b1 && !prev_req) begin
      if (exp_q.size() == 0) chk("rnd_unexpected_req", 1, 0);
      else begin
        cur     = exp_q.pop_front();
        req_cyc = 0;
      end
    end
    chk("rnd_ready", ls_ready, exp_q.size() < DEPTH);
    if (ack_prev) chk("rnd_req_drop", mem_req, 0);
    if (mem_req === 1'b1) begin
      req_cyc++;
      chk("rnd_addr", mem_addr, cur.addr);
      chk("rnd_we", mem_we, !cur.rd);
      if (!cur.rd) chk("rnd_wdata", mem_wdata, cur.data);
      chk("rnd_one_outstanding", wb_exp.size(), 0);
    end
    chk("rnd_wb_valid", wb_valid, wb_exp.size() != 0);
    if (wb_valid === 1'b1 && wb_exp.size() != 0) begin
      chk("rnd_wb_data", wb_data, wb_exp[0].data);
      chk("rnd_wb_tag", wb_tag, wb_exp[0].tag);
    end
    chk("rnd_bus_err", bus_err, 0);
    prev_req = (mem_req === 1'b1);

    wb_ready = ($urandom_range(0, 2) != 0);
    if (wb_valid === 1'b1 && wb_ready && wb_exp.size() != 0) void'(wb_exp.pop_front());
    mem_rdata = 8'($urandom);
    if (prev_req) mem_ack = ($urandom_range(0, 3) == 0) || (req_cyc >= 30);
    else mem_ack = ($urandom_range(0, 7) == 0);
    ack_prev = mem_ack && prev_req;
    if (ack_prev && cur.rd) wb_exp.push_back('{tag: cur.tag, data: {8'h00, mem_rdata}});
    r = '{rd: 1'($urandom), addr: 25'($urandom), data: 8'($urandom), tag: 5'($urandom)};
    drive_ls(r);
    ls_valid = gen && ($urandom_range(0, 1) == 1);
    if (ls_valid && ls_ready === 1'b1) exp_q.push_back(r);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t fill[DEPTH+1];
    req_t ra;
    req_t rb;
    logic last_idle_ready;
    logic [7:0] rb_byte;
    int   w;
    bit   done;

    vecs[0] = '{1'b1, 25'h1ABCDE,  8'h00, 5'd7,  3,     8'hA5, 0, 4,  1'b0, 1'b1, 16'h00A5};
    vecs[1] = '{1'b0, 25'h0000010, 8'h3C, 5'd3,  1,     8'h77, 0, 2,  1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 25'h00155AA, 8'h00, 5'd31, 0,     8'hFF, 2, 1,  1'b0, 1'b1, 16'h00FF};
    vecs[3] = '{1'b1, 25'h1FFFFFF, 8'h00, 5'd0,  NEVER, 8'h11, 0, 64, 1'b1, 1'b1, 16'h0000};
    vecs[4] = '{1'b0, 25'h00000FF, 8'h81, 5'd9,  NEVER, 8'h22, 0, 64, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 25'h0000000, 8'h00, 5'd12, 63,    8'h5A, 0, 64, 1'b0, 1'b1, 16'h005A};
    vecs[6] = '{1'b0, 25'h1000001, 8'hE7, 5'd1,  62,    8'h33, 0, 63, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 25'h00ABCDE, 8'h00, 5'd18, 5,     8'h00, 5, 6,  1'b0, 1'b1, 16'h0000};

    rst = 1'b1; ls_valid = 1'b0; LS_addr = '0; LS_data = '0; LS_R_nW = 1'b0;
    LS_Rd_tag = '0; mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_ls_ready", ls_ready, 0);
    rst = 1'b0;
    chk("rel_ls_ready0", ls_ready, 0);
    tick();
    chk("rel_ls_ready1", ls_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Writeback backpressure with a second request already queued.
    ra = '{rd: 1'b1, addr: 25'h0000111, data: 8'h00, tag: 5'd4};
    rb = '{rd: 1'b1, addr: 25'h0000222, data: 8'h00, tag: 5'd5};
    drive_ls(ra);
    tick();
    drive_ls(rb);
    tick();
    ls_valid = 1'b0;
    chk("bp_req_a", mem_req, 1);
    chk("bp_addr_a", mem_addr, ra.addr);
    mem_ack = 1'b1; mem_rdata = 8'h3E;
    tick();
    mem_ack = 1'b0;
    chk("bp_wb_valid", wb_valid, 1);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("bp_hold_valid", wb_valid, 1);
      chk("bp_hold_data", wb_data, 16'h003E);
      chk("bp_hold_tag", wb_tag, ra.tag);
      chk("bp_no_next_req", mem_req, 0);
    end
    wb_ready = 1'b1;
    tick();
    chk("bp_accept", wb_valid, 0);
    tick();
    chk("bp_req_b", mem_req, 1);
    chk("bp_addr_b", mem_addr, rb.addr);
    mem_ack = 1'b1; mem_rdata = 8'h9D;
    tick();
    mem_ack = 1'b0;
    chk("bp_wb_b_data", wb_data, 16'h009D);
    chk("bp_wb_b_tag", wb_tag, rb.tag);
    tick();
    wb_ready = 1'b0;
    chk("bp_done", wb_valid, 0);

    // Fill the queue with the bus stalled, then drain it in order.
    for (int i = 0; i <= DEPTH; i++) begin
      fill[i] = '{rd: (i % 2 == 0), addr: 25'h100000 + 25'(i * 32'h1111),
                  data: 8'h50 + 8'(i), tag: 5'd20 + 5'(i)};
      drive_ls(fill[i]);
      chk("fill_ready", ls_ready, 1);
      tick();
    end
    drive_ls('{rd: 1'b0, addr: 25'h0DEAD0, data: 8'hEE, tag: 5'd0});
    chk("fill_full", ls_ready, 0);
    tick();
    chk("fill_full_hold", ls_ready, 0);
    chk("fill_head_busy", mem_req, 1);
    ls_valid = 1'b0;
    wb_ready = 1'b1;
    last_idle_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      w = 0;
      while (mem_req !== 1'b1 && w < 20) begin
        last_idle_ready = ls_ready;
        tick();
        w++;
      end
      chk("fill_req_start", mem_req, 1);
      chk("fill_order_addr", mem_addr, fill[i].addr);
      chk("fill_order_we", mem_we, !fill[i].rd);
      if (i == 1) begin
        chk("fill_no_bypass", last_idle_ready, 0);
        chk("fill_ready_after_pop", ls_ready, 1);
      end
      tick();
      rb_byte = 8'hC0 + 8'(i);
      mem_ack = 1'b1; mem_rdata = rb_byte;
      tick();
      mem_ack = 1'b0;
      chk("fill_wb_valid", wb_valid, fill[i].rd);
      if (fill[i].rd) begin
        chk("fill_wb_data", wb_data, {8'h00, rb_byte});
        chk("fill_wb_tag", wb_tag, fill[i].tag);
      end
    end
    for (int i = 0; i < 5; i++) tick();
    chk("fill_no_extra", mem_req, 0);
    wb_ready = 1'b0;

    // Reset while a load is on the bus and two more are queued.
    for (int i = 0; i < 3; i++) begin
      drive_ls('{rd: 1'b1, addr: 25'h0040000 + 25'(i), data: 8'h00, tag: 5'(i + 1)});
      tick();
    end
    ls_valid = 1'b0;
    chk("mid_req_active", mem_req, 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h66;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_wb", wb_valid, 0);
    chk("mid_rst_err", bus_err, 0);
    chk("mid_rst_ready0", ls_ready, 0);
    tick();
    chk("mid_rst_ready1", ls_ready, 1);
    for (int i = 0; i < 10; i++) begin
      chk("mid_rst_no_wb", wb_valid, 0);
      chk("mid_rst_no_req", mem_req, 0);
      tick();
    end

    // Randomized traffic against the transaction model.
    exp_q.delete(); wb_exp.delete();
    prev_req = 1'b0; ack_prev = 1'b0; req_cyc = 0;
    cur = '0;
    for (int c = 0; c < 1500; c++) rand_step(1'b1);
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      rand_step(1'b0);
      done = (exp_q.size() == 0) && (wb_exp.size() == 0) && !prev_req && !ack_prev;
    end
    chk("rnd_drain_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
